// File: rtl/muon_pulse_gen_if.sv
// Control and status bundle of the muon pulse generator.
// The master side is the run controller. The slave side is the generator itself.
interface muon_pulse_gen_if;
    logic        enable;
    logic        mode;
    logic [8:0]  delay_ticks;
    logic [15:0] n_events;
    logic        pulse_out;
    logic        busy;
    logic        pair_done;
    logic [8:0]  delay_out;
    logic [15:0] events_sent;
    logic        done;

    modport master (
        output enable, mode, delay_ticks, n_events,
        input  pulse_out, busy, pair_done, delay_out, events_sent, done
    );

    modport slave (
        input  enable, mode, delay_ticks, n_events,
        output pulse_out, busy, pair_done, delay_out, events_sent, done
    );
endinterface

// File: rtl/muon_pulse_gen.sv
// Synthetic muon-decay source.
// Each pair is a capture pulse followed by a decay pulse.
// The gap between the two rising edges is D delay ticks, where D is either
// fixed or pseudo-random. The generator reports each D it used.
module muon_pulse_gen #(
    parameter int          CLK_PER_TICK    = 4,
    parameter int          PULSE_WIDTH     = 2,
    parameter int          GAP_CLKS        = 16,
    parameter int          MAX_DELAY_TICKS = 500,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input logic             clk,
    input logic             reset,
    muon_pulse_gen_if.slave bus
);
    // An all-zero seed would lock the LFSR, so it falls back to the default seed
    localparam logic [15:0]       SEED        = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam int                PRE_W       = $clog2(CLK_PER_TICK);
    localparam int                CNT_MAX     = (GAP_CLKS > PULSE_WIDTH) ? GAP_CLKS : PULSE_WIDTH;
    localparam int                CNT_W       = $clog2(CNT_MAX + 1);
    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(CLK_PER_TICK - 1);
    localparam logic [PRE_W-1:0]  PW_LAST_PRE = PRE_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  PW_LAST     = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(GAP_CLKS - 1);
    localparam logic [9:0]        MAX_D       = 10'(MAX_DELAY_TICKS);

    typedef enum logic [2:0] {IDLE, PULSE1, WAIT, PULSE2, GAP, DONE} state_t;

    state_t             state;
    logic               pulse_reg;
    logic               busy_reg;
    logic               pair_done_reg;
    logic               done_reg;
    logic [15:0]        events_reg;
    logic [8:0]         delay_reg;
    logic [15:0]        n_ev;
    logic [15:0]        lfsr;
    logic [PRE_W-1:0]   pre;
    logic [8:0]         ticks;
    logic [CNT_W-1:0]   cnt;

    logic [8:0]         start_delay;
    logic               run_end;
    logic               gap_end;
    logic               wait_end;
    logic               pulse1_end;
    logic               start_pair;

    // Fold a raw 9-bit delay into the range [1, MAX_DELAY_TICKS-1]
    function automatic logic [8:0] fold_delay(input logic [8:0] raw);
        logic [8:0] r;
        r = raw;
        if ({1'b0, raw} >= MAX_D) r = 9'({1'b0, raw} - MAX_D);
        if (r == 9'd0) r = 9'd1;
        return r;
    endfunction

    // Saturating pair counter increment
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Fibonacci LFSR step with taps 16,14,13,11, shifting left into bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Decode pair boundaries; a pair starts from IDLE or from the end of a GAP
    always_comb begin
        start_delay = fold_delay(bus.mode ? lfsr[8:0] : bus.delay_ticks);
        run_end     = (n_ev != 16'd0) && (events_reg == n_ev);
        gap_end     = (state == GAP) && (cnt == GAP_LAST);
        wait_end    = (pre == PRE_LAST) && (ticks == delay_reg - 9'd1);
        pulse1_end  = (ticks == 9'd0) && (pre == PW_LAST_PRE);
        start_pair  = bus.enable && ((state == IDLE) || (gap_end && !run_end));
    end

    // Latch the pair settings at pair start; the LFSR advances after being sampled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr      <= SEED;
            delay_reg <= 9'd0;
            n_ev      <= 16'd0;
        end else if (start_pair) begin
            delay_reg <= start_delay;
            n_ev      <= bus.n_events;
            if (bus.mode) lfsr <= lfsr_next(lfsr);
        end
    end

    // The tick prescaler and the tick counter measure time from the first pulse rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre   <= '0;
            ticks <= 9'd0;
        end else if (start_pair) begin
            pre   <= '0;
            ticks <= 9'd0;
        end else if (state == PULSE1 || state == WAIT) begin
            if (pre == PRE_LAST) begin
                pre   <= '0;
                ticks <= ticks + 9'd1;
            end else begin
                pre <= pre + PRE_W'(1);
            end
        end
    end

    // Pair sequencer; every output leaves this block registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            pulse_reg     <= 1'b0;
            busy_reg      <= 1'b0;
            pair_done_reg <= 1'b0;
            done_reg      <= 1'b0;
            events_reg    <= 16'd0;
            cnt           <= '0;
        end else begin
            pair_done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_pair) begin
                        state      <= PULSE1;
                        pulse_reg  <= 1'b1;
                        busy_reg   <= 1'b1;
                        events_reg <= 16'd0;
                    end
                end
                PULSE1: begin
                    if (pulse1_end) begin
                        state     <= WAIT;
                        pulse_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wait_end) begin
                        state     <= PULSE2;
                        pulse_reg <= 1'b1;
                        cnt       <= '0;
                    end
                end
                PULSE2: begin
                    if (cnt == PW_LAST) begin
                        state         <= GAP;
                        pulse_reg     <= 1'b0;
                        pair_done_reg <= 1'b1;
                        events_reg    <= sat_inc(events_reg);
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        if (run_end) begin
                            state    <= DONE;
                            busy_reg <= 1'b0;
                            done_reg <= 1'b1;
                        end else if (start_pair) begin
                            state     <= PULSE1;
                            pulse_reg <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            busy_reg <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!bus.enable) begin
                        state    <= IDLE;
                        done_reg <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pulse_out   = pulse_reg;
    assign bus.busy        = busy_reg;
    assign bus.pair_done   = pair_done_reg;
    assign bus.delay_out   = delay_reg;
    assign bus.events_sent = events_reg;
    assign bus.done        = done_reg;
endmodule

// File: tb/tb_muon_pulse_gen.sv
// Bench for the muon pulse generator.
// A negedge monitor collects pulse rise times, pulse widths and pair reports.
// Expected delays and spacings come from a plain-arithmetic model.
module tb_muon_pulse_gen;
    localparam int          CPT  = 4;
    localparam int          PW   = 2;
    localparam int          GAP  = 16;
    localparam int          MAXD = 500;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int unsigned cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    muon_pulse_gen_if bus ();

    muon_pulse_gen #(
        .CLK_PER_TICK(CPT), .PULSE_WIDTH(PW), .GAP_CLKS(GAP),
        .MAX_DELAY_TICKS(MAXD), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state
    int rises[$];
    int widths[$];
    int pd_es[$];
    int pd_d[$];
    int pd_cyc[$];
    int t4_d[$];
    bit mon_clear = 1'b0;
    bit prev_pulse = 1'b0;
    int hi_len = 0;
    logic [15:0] model_lfsr = SEED;

    always @(negedge clk) begin
        if (mon_clear) begin
            rises.delete(); widths.delete(); pd_es.delete(); pd_d.delete(); pd_cyc.delete();
        end
        if (!reset) begin
            prev_pulse = 1'b0;
            hi_len = 0;
        end else begin
            if (bus.pulse_out && !prev_pulse) rises.push_back(int'(cyc));
            if (bus.pulse_out) hi_len++;
            else if (prev_pulse) begin
                widths.push_back(hi_len);
                hi_len = 0;
            end
            if (bus.pair_done) begin
                pd_es.push_back(int'(bus.events_sent));
                pd_d.push_back(int'(bus.delay_out));
                pd_cyc.push_back(int'(cyc));
            end
            prev_pulse = bus.pulse_out;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_delay(input int raw);
        int r;
        r = raw % MAXD;
        return (r == 0) ? 1 : r;
    endfunction

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    task automatic clear_mon();
        mon_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_clear = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_pulse"}, 32'(bus.pulse_out), 0);
        check_val({tag, "_busy"}, 32'(bus.busy), 0);
        check_val({tag, "_pdone"}, 32'(bus.pair_done), 0);
        check_val({tag, "_delay"}, 32'(bus.delay_out), 0);
        check_val({tag, "_events"}, 32'(bus.events_sent), 0);
        check_val({tag, "_done"}, 32'(bus.done), 0);
    endtask

    task automatic do_run(input bit m, input logic [8:0] dt, input int nev, input string tag);
        int exp_d[$];
        int budget;
        for (int k = 0; k < nev; k++) begin
            if (m) begin
                exp_d.push_back(ref_delay(int'(model_lfsr[8:0])));
                model_lfsr = ref_step(model_lfsr);
            end else begin
                exp_d.push_back(ref_delay(int'(dt)));
            end
        end
        clear_mon();
        bus.mode = m;
        bus.delay_ticks = dt;
        bus.n_events = 16'(nev);
        bus.enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val({tag, "_busy_run"}, 32'(bus.busy), 1);
        budget = nev * (512 * CPT + 2 * PW + GAP + 8) + 50;
        while (!bus.done && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val({tag, "_done"}, 32'(bus.done), 1);
        check_val({tag, "_busy_at_done"}, 32'(bus.busy), 0);
        check_val({tag, "_n_rises"}, 32'(rises.size()), 32'(2 * nev));
        check_val({tag, "_n_pairs"}, 32'(pd_es.size()), 32'(nev));
        foreach (widths[i]) check_val({tag, "_width"}, 32'(widths[i]), PW);
        for (int k = 0; k < nev; k++) begin
            if (pd_es.size() > k) begin
                check_val({tag, "_events_seq"}, 32'(pd_es[k]), 32'(k + 1));
                check_val({tag, "_delay_out"}, 32'(pd_d[k]), 32'(exp_d[k]));
                if (m) check_val({tag, "_delay_range"}, 32'(pd_d[k] >= 1 && pd_d[k] < MAXD), 1);
            end
            if (rises.size() > 2 * k + 1)
                check_val({tag, "_spacing"}, 32'(rises[2*k+1] - rises[2*k]), 32'(exp_d[k] * CPT));
            if (k + 1 < nev && rises.size() > 2 * k + 2)
                check_val({tag, "_period"}, 32'(rises[2*k+2] - rises[2*k]), 32'(exp_d[k] * CPT + PW + GAP));
        end
        check_val({tag, "_events_final"}, 32'(bus.events_sent), 32'(nev));
        check_val({tag, "_delay_final"}, 32'(bus.delay_out), 32'(exp_d[nev-1]));
        bus.enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val({tag, "_done_clr"}, 32'(bus.done), 0);
        check_val({tag, "_busy_idle"}, 32'(bus.busy), 0);
        check_val({tag, "_events_hold"}, 32'(bus.events_sent), 32'(nev));
    endtask

    initial begin
        int budget;
        int fall_cyc;
        bus.enable = 1'b0;
        bus.mode = 1'b0;
        bus.delay_ticks = 9'd0;
        bus.n_events = 16'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        // Basic fixed-delay pair and the delay folding corners
        do_run(1'b0, 9'd10, 1, "t1");
        do_run(1'b0, 9'd0, 1, "t2_zero");
        do_run(1'b0, 9'd511, 1, "t2_511");
        do_run(1'b0, 9'd499, 1, "t2_499");
        do_run(1'b0, 9'd10, 3, "t3");

        // Random fixed-mode runs
        for (int r = 0; r < 3; r++)
            do_run(1'b0, 9'($urandom_range(0, 511)), int'($urandom_range(1, 2)), "rnd_fixed");

        // LFSR mode from the reset seed
        do_run(1'b1, 9'd0, 8, "t4");
        t4_d = pd_d;

        // Continuous run with enable dropped during WAIT
        clear_mon();
        bus.mode = 1'b0;
        bus.delay_ticks = 9'd10;
        bus.n_events = 16'd0;
        bus.enable = 1'b1;
        budget = 100;
        while (rises.size() < 1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val("t5_first_rise", 32'(rises.size()), 1);
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        budget = 200;
        while (bus.busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        fall_cyc = int'(cyc);
        check_val("t5_busy_fall", 32'(bus.busy), 0);
        check_val("t5_n_rises", 32'(rises.size()), 2);
        check_val("t5_n_pairs", 32'(pd_es.size()), 1);
        if (rises.size() > 1) check_val("t5_spacing", 32'(rises[1] - rises[0]), 32'(10 * CPT));
        if (pd_cyc.size() > 0) check_val("t5_gap_len", 32'(fall_cyc - pd_cyc[0]), GAP);
        check_val("t5_done", 32'(bus.done), 0);
        check_val("t5_events", 32'(bus.events_sent), 1);
        repeat (20) @(negedge clk);
        check_val("t5_no_more_pulses", 32'(rises.size()), 2);

        // Reset during the second pulse of a random run
        clear_mon();
        bus.mode = 1'b1;
        bus.n_events = 16'd8;
        bus.enable = 1'b1;
        budget = 3000;
        while (rises.size() < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_val("t6_pulse2_seen", 32'(bus.pulse_out), 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("t6_async");
        bus.enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_lfsr = SEED;
        do_run(1'b1, 9'd0, 8, "t6_rerun");
        for (int k = 0; k < 8; k++)
            if (pd_d.size() > k && t4_d.size() > k)
                check_val("t6_repeat_seq", 32'(pd_d[k]), 32'(t4_d[k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
